// File: rtl/axi4_bram_slave_if.sv
// AXI4 subset bundle (AW/W/B/AR/R with ID, LEN, BURST, WSTRB) on a 32-bit data path.
// The master modport is the bridge side; the slave modport is the memory side.
interface axi4_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_bram_slave.sv
// AXI4 responder backed by block RAM, one transaction at a time.
// Read beats go through a 2-entry skid buffer so rready=1 streams without bubbles.
module axi4_bram_slave #(
  parameter int          DEPTH = 1024,
  parameter int          ID_W  = 4,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst,
  axi4_if.slave axi4
);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [32:0] WIN   = 33'(DEPTH) * 33'd4;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;
  state_t state, state_next;

  logic [31:0]      mem [DEPTH];
  logic [ID_W-1:0]  id_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       cnt_q;
  logic             fixed_q, decerr_q, slverr_q, iss_done_q;
  logic [31:0]      buf_data [2];
  logic [1:0]       buf_last;
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count;

  logic        aw_hs, ar_hs, w_hs, w_end, r_pop, r_issue, r_end, in_win;
  logic [31:0] addr_sel, off;

  always_comb begin
    aw_hs    = (state == IDLE) && !rst && axi4.awvalid;
    ar_hs    = (state == IDLE) && !rst && !axi4.awvalid && axi4.arvalid;
    addr_sel = axi4.awvalid ? axi4.awaddr : axi4.araddr;
    off      = addr_sel - BASE;
    in_win   = (addr_sel >= BASE) && ({1'b0, off} < WIN);
    w_hs     = (state == WR_DATA) && axi4.wvalid;
    w_end    = w_hs && (axi4.wlast || (cnt_q == 8'd0));
    r_pop    = (count != 2'd0) && axi4.rready;
    r_issue  = ((state == RD_ADDR) || (state == RD_DATA)) && !iss_done_q &&
               ((count != 2'd2) || r_pop);
    r_end    = r_pop && buf_last[rd_ptr];
    state_next = state;
    unique case (state)
      IDLE:    if (aw_hs) state_next = WR_DATA;
               else if (ar_hs) state_next = RD_ADDR;
      WR_DATA: if (w_end) state_next = WR_RESP;
      WR_RESP: if (axi4.bready) state_next = IDLE;
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: if (r_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      fixed_q     <= 1'b0;
      decerr_q    <= 1'b0;
      slverr_q    <= 1'b0;
      iss_done_q  <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
    end else begin
      if (aw_hs || ar_hs) begin
        id_q       <= aw_hs ? axi4.awid : axi4.arid;
        idx_q      <= off[IDX_W+1:2];
        cnt_q      <= aw_hs ? axi4.awlen : axi4.arlen;
        fixed_q    <= (aw_hs ? axi4.awburst : axi4.arburst) == 2'b00;
        decerr_q   <= !in_win;
        slverr_q   <= 1'b0;
        iss_done_q <= 1'b0;
      end
      if (w_hs) begin
        if (axi4.wlast != (cnt_q == 8'd0)) slverr_q <= 1'b1;
        if (!w_end) begin
          cnt_q <= cnt_q - 8'd1;
          if (!fixed_q) idx_q <= idx_q + 1'b1;
        end
      end
      // Entries are filled straight from RAM; count tracks occupancy incl. the same-cycle pop.
      if (r_issue) begin
        buf_data[wr_ptr] <= decerr_q ? 32'd0 : mem[idx_q];
        buf_last[wr_ptr] <= (cnt_q == 8'd0);
        wr_ptr           <= ~wr_ptr;
        if (cnt_q == 8'd0) iss_done_q <= 1'b1;
        else begin
          cnt_q <= cnt_q - 8'd1;
          if (!fixed_q) idx_q <= idx_q + 1'b1;
        end
      end
      if (r_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(r_issue) - 2'(r_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !decerr_q) begin
      for (int b = 0; b < 4; b++)
        if (axi4.wstrb[b]) mem[idx_q][8*b +: 8] <= axi4.wdata[8*b +: 8];
    end
  end

  assign axi4.awready = aw_hs;
  assign axi4.arready = ar_hs;
  assign axi4.wready  = (state == WR_DATA);
  assign axi4.bvalid  = (state == WR_RESP);
  assign axi4.bid     = id_q;
  assign axi4.bresp   = (state != WR_RESP) ? 2'b00 :
                        decerr_q ? 2'b11 : slverr_q ? 2'b10 : 2'b00;
  assign axi4.rvalid  = (count != 2'd0);
  assign axi4.rdata   = buf_data[rd_ptr];
  assign axi4.rlast   = (count != 2'd0) && buf_last[rd_ptr];
  assign axi4.rid     = id_q;
  assign axi4.rresp   = ((count != 2'd0) && decerr_q) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_axi4_bram_slave.sv
// Self-checking bench for axi4_bram_slave: memory model plus a read-beat scoreboard queue.
module tb_axi4_bram_slave;
  localparam int          DEPTH = 1024;
  localparam int          ID_W  = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
    logic [ID_W-1:0] id;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_if #(.ID_W(ID_W)) axi4 ();
  axi4_bram_slave #(.DEPTH(DEPTH), .ID_W(ID_W), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .axi4(axi4)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wdat [256];
  beat_t       exp_q [$];
  int          rr_pat [$];

  function automatic bit in_win(input logic [31:0] addr);
    return (addr >= BASE) && ((addr - BASE) < 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] addr, input int b, input logic [1:0] burst);
    int base_i;
    base_i = int'((addr - BASE) >> 2) % DEPTH;
    return (burst == 2'b00) ? base_i : (base_i + b) % DEPTH;
  endfunction

  function automatic void push_expected(input logic [31:0] addr, input int len,
                                        input logic [1:0] burst, input logic [ID_W-1:0] id);
    for (int b = 0; b <= len; b++) begin
      beat_t e;
      e.data = in_win(addr) ? model[widx(addr, b, burst)] : 32'd0;
      e.resp = in_win(addr) ? 2'b00 : 2'b11;
      e.last = (b == len);
      e.id   = id;
      exp_q.push_back(e);
    end
  endfunction

  task automatic idle_inputs();
    axi4.awid = '0; axi4.awaddr = '0; axi4.awlen = '0; axi4.awburst = 2'b01; axi4.awvalid = 1'b0;
    axi4.wdata = '0; axi4.wstrb = '0; axi4.wlast = 1'b0; axi4.wvalid = 1'b0; axi4.bready = 1'b0;
    axi4.arid = '0; axi4.araddr = '0; axi4.arlen = '0; axi4.arburst = 2'b01; axi4.arvalid = 1'b0;
    axi4.rready = 1'b0;
  endtask

  task automatic write_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb, input int nbeats,
                             input int wlast_idx, input logic [1:0] exp_resp, input string name);
    int t;
    logic [1:0] held_resp;
    @(negedge clk);
    axi4.awid = id; axi4.awaddr = addr; axi4.awlen = len; axi4.awburst = burst; axi4.awvalid = 1'b1;
    #1; t = 0;
    while (axi4.awready !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
    checks++;
    if (axi4.awready !== 1'b1) begin
      failures++; $display("FAIL %s awready: got %b want 1", name, axi4.awready);
      axi4.awvalid = 1'b0; return;
    end
    @(posedge clk); #1;
    axi4.awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      axi4.wvalid = 1'b1; axi4.wdata = wdat[b]; axi4.wstrb = strb; axi4.wlast = (b == wlast_idx);
      checks++;
      if (axi4.wready !== 1'b1) begin
        failures++; $display("FAIL %s wready beat %0d: got %b want 1", name, b, axi4.wready);
        axi4.wvalid = 1'b0; return;
      end
      @(posedge clk); #1;
      if (in_win(addr)) begin
        int i;
        i = widx(addr, b, burst);
        for (int k = 0; k < 4; k++) if (strb[k]) model[i][8*k +: 8] = wdat[b][8*k +: 8];
      end
    end
    axi4.wvalid = 1'b0; axi4.wlast = 1'b0;
    checks++;
    if (axi4.wready !== 1'b0 || axi4.bvalid !== 1'b1) begin
      failures++;
      $display("FAIL %s burst end: got wready=%b bvalid=%b want 0/1", name, axi4.wready, axi4.bvalid);
    end
    held_resp = axi4.bresp;
    @(posedge clk); #1;
    checks++;
    if (axi4.bvalid !== 1'b1 || axi4.bresp !== held_resp) begin
      failures++;
      $display("FAIL %s b hold: got bvalid=%b bresp=%b want 1/%b", name, axi4.bvalid, axi4.bresp, held_resp);
    end
    axi4.bready = 1'b1;
    checks++;
    if (axi4.bresp !== exp_resp || axi4.bid !== id) begin
      failures++;
      $display("FAIL %s bresp/bid: got %b/%0d want %b/%0d", name, axi4.bresp, axi4.bid, exp_resp, id);
    end
    @(posedge clk); #1;
    axi4.bready = 1'b0;
    checks++;
    if (axi4.bvalid !== 1'b0) begin
      failures++; $display("FAIL %s bvalid after B: got %b want 0", name, axi4.bvalid);
    end
  endtask

  task automatic collect_read(input string name);
    int lat, cyc, pi;
    bit held;
    beat_t hv;
    lat = 1; cyc = 0; pi = 0; held = 1'b0;
    while (axi4.rvalid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 2) begin
      failures++; $display("FAIL %s first-beat latency: got %0d want 2", name, lat);
    end
    while (exp_q.size() > 0 && cyc < 1000) begin
      if (held) begin
        checks++;
        if (axi4.rvalid !== 1'b1 || axi4.rdata !== hv.data || axi4.rlast !== hv.last ||
            axi4.rresp !== hv.resp || axi4.rid !== hv.id) begin
          failures++;
          $display("FAIL %s stall hold: got v=%b d=%h l=%b want 1/%h/%b", name, axi4.rvalid,
                   axi4.rdata, axi4.rlast, hv.data, hv.last);
        end
      end
      axi4.rready = (pi < rr_pat.size()) ? (rr_pat[pi] != 0) : 1'b1;
      pi++;
      held = 1'b0;
      if (axi4.rvalid === 1'b1) begin
        if (axi4.rready) begin
          beat_t e;
          e = exp_q.pop_front();
          checks++;
          if (axi4.rdata !== e.data || axi4.rresp !== e.resp || axi4.rlast !== e.last || axi4.rid !== e.id) begin
            failures++;
            $display("FAIL %s beat: got d=%h r=%b l=%b id=%0d want d=%h r=%b l=%b id=%0d", name,
                     axi4.rdata, axi4.rresp, axi4.rlast, axi4.rid, e.data, e.resp, e.last, e.id);
          end
        end else begin
          held = 1'b1;
          hv.data = axi4.rdata; hv.resp = axi4.rresp; hv.last = axi4.rlast; hv.id = axi4.rid;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    axi4.rready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || axi4.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL %s read end: got left=%0d rvalid=%b want 0/0", name, exp_q.size(), axi4.rvalid);
    end
    exp_q.delete();
    rr_pat.delete();
  endtask

  task automatic read_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input string name);
    int t;
    push_expected(addr, int'(len), burst, id);
    @(negedge clk);
    axi4.arid = id; axi4.araddr = addr; axi4.arlen = len; axi4.arburst = burst; axi4.arvalid = 1'b1;
    #1; t = 0;
    while (axi4.arready !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
    checks++;
    if (axi4.arready !== 1'b1) begin
      failures++; $display("FAIL %s arready: got %b want 1", name, axi4.arready);
      axi4.arvalid = 1'b0; exp_q.delete(); return;
    end
    @(posedge clk); #1;
    axi4.arvalid = 1'b0;
    collect_read(name);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (axi4.awready !== 0 || axi4.arready !== 0 || axi4.wready !== 0 || axi4.bvalid !== 0 ||
        axi4.rvalid !== 0 || axi4.rlast !== 0 || axi4.bresp !== 0 || axi4.rresp !== 0 ||
        axi4.rdata !== 0 || axi4.bid !== 0 || axi4.rid !== 0) begin
      failures++;
      $display("FAIL reset outputs: got aw=%b ar=%b w=%b b=%b r=%b rdata=%h want all 0", axi4.awready,
               axi4.arready, axi4.wready, axi4.bvalid, axi4.rvalid, axi4.rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    wdat[0] = 32'hDEADBEEF;
    write_burst(4'd1, 32'h10, 8'd0, 2'b01, 4'hF, 1, 0, 2'b00, "single_wr");
    read_burst(4'd2, 32'h10, 8'd0, 2'b01, "single_rd");
    checks++;
    if (model[4] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single model: got %h want deadbeef", model[4]);
    end
  endtask

  task automatic test_byte_strobe();
    wdat[0] = 32'h11223344;
    write_burst(4'd3, 32'h20, 8'd0, 2'b01, 4'hF, 1, 0, 2'b00, "strb_init");
    wdat[0] = 32'hAABBCCDD;
    write_burst(4'd3, 32'h20, 8'd0, 2'b01, 4'b0110, 1, 0, 2'b00, "strb_wr");
    push_expected(32'h20, 0, 2'b01, 4'd4);
    checks++;
    if (exp_q[0].data !== 32'h11BBCC44) begin
      failures++; $display("FAIL strb expected: got %h want 11bbcc44", exp_q[0].data);
    end
    exp_q.delete();
    read_burst(4'd4, 32'h20, 8'd0, 2'b01, "strb_rd");
  endtask

  task automatic test_incr_wrap();
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    write_burst(4'd5, 32'hFF8, 8'd3, 2'b01, 4'hF, 4, 3, 2'b00, "wrap_wr");
    read_burst(4'd6, 32'hFF8, 8'd3, 2'b01, "wrap_rd");
    read_burst(4'd7, 32'h0, 8'd1, 2'b01, "wrap_low_rd");
  endtask

  task automatic test_fixed_burst();
    for (int i = 0; i < 3; i++) wdat[i] = 32'hF0 + 32'(i);
    write_burst(4'd8, 32'h300, 8'd2, 2'b00, 4'hF, 3, 2, 2'b00, "fixed_wr");
    read_burst(4'd8, 32'h300, 8'd2, 2'b00, "fixed_rd");
  endtask

  task automatic test_backpressure();
    rr_pat = '{1, 0, 0, 1, 1, 0, 1};
    read_burst(4'd9, 32'hFF8, 8'd3, 2'b01, "bp_rd");
    rr_pat = '{0, 1, 0, 1, 0, 1, 0, 1};
    read_burst(4'd9, 32'hFF8, 8'd3, 2'b01, "bp_alt_rd");
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) wdat[i] = 32'hE000 + 32'(i);
    write_burst(4'd10, 32'h200, 8'd3, 2'b01, 4'hF, 2, 1, 2'b10, "early_wlast");
    write_burst(4'd11, 32'h240, 8'd1, 2'b01, 4'hF, 2, -1, 2'b10, "missing_wlast");
    read_burst(4'd10, 32'h200, 8'd1, 2'b01, "early_rd");
    wdat[0] = 32'hBADBAD00;
    write_burst(4'd12, BASE + 32'(DEPTH * 4), 8'd0, 2'b01, 4'hF, 1, 0, 2'b11, "decerr_wr");
    read_burst(4'd12, 32'h0, 8'd0, 2'b01, "decerr_alias_rd");
    read_burst(4'd13, BASE + 32'(DEPTH * 4), 8'd1, 2'b01, "decerr_rd");
  endtask

  task automatic test_arbitration();
    wdat[0] = 32'hCAFEF00D;
    @(negedge clk);
    axi4.awid = 4'd5; axi4.awaddr = 32'h40; axi4.awlen = 8'd0; axi4.awburst = 2'b01; axi4.awvalid = 1'b1;
    axi4.arid = 4'd6; axi4.araddr = 32'h40; axi4.arlen = 8'd0; axi4.arburst = 2'b01; axi4.arvalid = 1'b1;
    #1;
    checks++;
    if (axi4.awready !== 1'b1 || axi4.arready !== 1'b0) begin
      failures++; $display("FAIL arb first: got aw=%b ar=%b want 1/0", axi4.awready, axi4.arready);
    end
    @(posedge clk); #1;
    axi4.awvalid = 1'b0;
    axi4.wvalid = 1'b1; axi4.wdata = wdat[0]; axi4.wstrb = 4'hF; axi4.wlast = 1'b1;
    @(posedge clk); #1;
    axi4.wvalid = 1'b0; axi4.wlast = 1'b0;
    model[16] = wdat[0];
    checks++;
    if (axi4.arready !== 1'b0 || axi4.bvalid !== 1'b1) begin
      failures++; $display("FAIL arb during B: got ar=%b bvalid=%b want 0/1", axi4.arready, axi4.bvalid);
    end
    axi4.bready = 1'b1;
    @(posedge clk); #1;
    axi4.bready = 1'b0;
    checks++;
    if (axi4.arready !== 1'b1) begin
      failures++; $display("FAIL arb ar after B: got %b want 1", axi4.arready);
    end
    push_expected(32'h40, 0, 2'b01, 4'd6);
    @(posedge clk); #1;
    axi4.arvalid = 1'b0;
    collect_read("arb_rd");
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 8; i++) wdat[i] = 32'h5A5A_0000 + 32'(i * 17);
    write_burst(4'd14, 32'h100, 8'd7, 2'b01, 4'hF, 8, 7, 2'b00, "rst_prep_wr");
    @(negedge clk);
    axi4.arid = 4'd15; axi4.araddr = 32'h100; axi4.arlen = 8'd7; axi4.arburst = 2'b01; axi4.arvalid = 1'b1;
    @(posedge clk); #1;
    axi4.arvalid = 1'b0;
    axi4.rready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (axi4.rvalid !== 1'b0 || axi4.rlast !== 1'b0) begin
      failures++; $display("FAIL rst mid read: got rvalid=%b rlast=%b want 0/0", axi4.rvalid, axi4.rlast);
    end
    rst = 1'b0;
    axi4.rready = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    read_burst(4'd15, 32'h100, 8'd7, 2'b01, "rst_after_rd");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_byte_strobe();
    test_incr_wrap();
    test_fixed_burst();
    test_backpressure();
    test_errors();
    test_arbitration();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_bram_slave.md
Name: axi4_bram_slave

Overview:
- AXI4 responder (slave) backed by on-chip block RAM, implementing the same AXI4 subset the DDR3 controller exposes to the UART command engine (AW/W/B/AR/R, ID, LEN, BURST, WSTRB).
- Serves as a drop-in substitute for ddr3_top behind the UART bridge: a small fast scratch memory and a simulation-friendly memory target.
- One transaction outstanding at a time; fixed 32-bit data path.

Parameters:
- DEPTH, 1024, memory size in 32-bit words; power of two, at least 2.
- ID_W, 4, width of the AXI ID fields.
- BASE, 32'h0000_0000, byte base address of the memory window; aligned to DEPTH*4.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- axi4_awid  in  ID_W  write address ID.
- axi4_awaddr  in  32  write byte address.
- axi4_awlen  in  8  write beats minus 1.
- axi4_awburst  in  2  0=FIXED, 1=INCR, 2/3 treated as INCR.
- axi4_awvalid  in  1  write address valid.
- axi4_awready  out  1  write address accept.
- axi4_wdata  in  32  write data.
- axi4_wstrb  in  4  write byte enables.
- axi4_wlast  in  1  last write beat.
- axi4_wvalid  in  1  write data valid.
- axi4_wready  out  1  write data accept.
- axi4_bid  out  ID_W  echoed awid.
- axi4_bresp  out  2  write response.
- axi4_bvalid  out  1  write response valid.
- axi4_bready  in  1  write response accept.
- axi4_arid  in  ID_W  read address ID.
- axi4_araddr  in  32  read byte address.
- axi4_arlen  in  8  read beats minus 1.
- axi4_arburst  in  2  same encoding as awburst.
- axi4_arvalid  in  1  read address valid.
- axi4_arready  out  1  read address accept.
- axi4_rid  out  ID_W  echoed arid.
- axi4_rdata  out  32  read data.
- axi4_rresp  out  2  read response.
- axi4_rlast  out  1  last read beat.
- axi4_rvalid  out  1  read data valid.
- axi4_rready  in  1  read data accept.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs driven to 0; state IDLE.
  - Memory contents are not cleared.
  - Reset during a burst aborts it; no B or R response is issued for the aborted transaction.
- States: IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - awready and arready are both 0 except in the single accept cycle.
  - If awvalid=1, the slave pulses awready=1 for exactly one cycle, latches id/addr/len/burst, and goes to WR_DATA.
  - Otherwise, if arvalid=1, the slave pulses arready for one cycle and goes to RD_ADDR.
  - Write has priority when awvalid and arvalid are high together. This preserves the host's write-then-read order.
- Address calculation:
  - word index = (addr - BASE)[..:2] taken modulo DEPTH.
  - addr[1:0] is ignored; byte lanes are selected by wstrb only.
  - INCR and WRAP: index increments by 1 per beat and wraps DEPTH-1 to 0. FIXED: index is held.
  - Out of window (addr < BASE or addr >= BASE + DEPTH*4, checked on the start address only): the burst is flagged DECERR.
- WR_DATA:
  - wready=1 for the whole state.
  - Each wvalid&&wready beat writes the byte lanes whose wstrb bit is 1; nothing is written when flagged DECERR.
  - A beat counter counts from len down to 0.
  - Leaves to WR_RESP on the beat where the counter reaches 0, or on a beat with wlast=1, whichever comes first.
  - If wlast disagrees with the counter (early wlast, or missing wlast on the final beat), bresp=SLVERR (2'b10).
- WR_RESP:
  - bvalid=1, bid=awid.
  - bresp: DECERR (2'b11) takes precedence over SLVERR, which takes precedence over OKAY (2'b00).
  - bvalid and bresp stay stable until bready=1, then the slave returns to IDLE.
  - When bready is already high, bvalid lasts one cycle.
- RD_ADDR: one cycle to issue the first BRAM read.
- RD_DATA timing:
  - First beat: rvalid=1 exactly 2 cycles after the arvalid&&arready cycle.
  - While rready=1, one beat per cycle with no bubbles. This needs a 2-entry output skid buffer.
- RD_DATA backpressure: while rvalid=1 and rready=0, rdata, rresp, rlast and rid are held stable.
- RD_DATA content:
  - rid = arid.
  - rlast=1 only on beat len.
  - rresp: OKAY, or DECERR with rdata=0 on every beat.
- RD_DATA exit: after the rlast beat is accepted, return to IDLE. A new AR can be accepted on the following cycle.
- Same-word read after write: a read issued after bvalid&&bready returns the newly written data. There is no hazard because only one transaction is outstanding.
- len=255 is supported (256 beats); the counter is 8 bits with no overflow.

Test Plan:
- Single write: awaddr=0x10, len=0, wdata=0xDEADBEEF, wstrb=4'hF; then read 0x10 -> bresp=0; rdata=0xDEADBEEF with rlast=1, rvalid 2 cycles after AR accept.
- Byte strobe: memory word holds 0x11223344; write wdata=0xAABBCCDD with wstrb=4'b0110 -> readback 0x11BBCC44.
- INCR burst with wrap: DEPTH=1024, awaddr=0xFF8, len=3, data 1,2,3,4 -> words 1022, 1023, 0, 1 hold 1,2,3,4; a 4-beat read from 0xFF8 returns 1,2,3,4 with rlast only on the 4th beat.
- Backpressure: 4-beat read with rready toggled 1,0,0,1,1,0,1 -> each beat is held stable while rready=0; exactly 4 beats delivered in order; rlast coincides with beat 4.
- Errors:
  - AW with len=3 and wlast on beat 2 -> bresp=2'b10; burst ends after beat 2.
  - araddr=BASE+DEPTH*4 -> rresp=2'b11, rdata=0.
- Arbitration and reset: awvalid and arvalid asserted in the same cycle -> awready fires first, arready only after the B handshake; rst=1 mid-read burst -> rvalid=0 on the next cycle, memory contents intact on a later read.
